// File: rtl/pipe_pkg.sv
// Shared definitions for the pipeline skid-register slice.
//   pipe_occ_t       : occupancy of a stage register (empty / main only / main + skid)
//   PIPE_DEF_WIDTH   : default stage bundle width
//   PIPE_STALL_CNT_W : width of the optional stall counter
package pipe_pkg;

    typedef enum logic [1:0] {
        OCC_EMPTY = 2'd0,
        OCC_HALF  = 2'd1,
        OCC_FULL  = 2'd2
    } pipe_occ_t;

    localparam int PIPE_DEF_WIDTH   = 32;
    localparam int PIPE_STALL_CNT_W = 32;

endpackage

// File: rtl/pipe_data_reg.sv
// Plain data register with a synchronous active-low reset to RST_VAL and a load enable.
// Ports:
//   clk    : clock
//   rst    : synchronous reset, active-low
//   i_load : capture i_d on this edge
//   i_d    : data in
//   o_q    : registered data
module pipe_data_reg
    import pipe_pkg::*;
#(
    parameter int               WIDTH   = PIPE_DEF_WIDTH,
    parameter logic [WIDTH-1:0] RST_VAL = {WIDTH{1'b0}}
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    logic [WIDTH-1:0] r_q;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_q <= RST_VAL;
        end else if (i_load) begin
            r_q <= i_d;
        end
    end

    assign o_q = r_q;

endmodule

// File: rtl/pipe_skid_reg.sv
// Pipeline-stage register with valid/ready handshake and a one-entry skid buffer,
// so in_ready is a flop with no combinational path from out_ready and the stage
// still sustains one transfer per cycle. Supports a synchronous flush (squash).
//
// Optional build macro: PIPE_SKID_STALL_CNT_EN adds the stall_cnt output, a
// saturating count of cycles with out_valid=1 and out_ready=0 (cleared by reset only).
//
// Ports:
//   clk        : clock
//   rst        : synchronous reset, active-low
//   flush      : squash all held entries
//   in_valid   : upstream presents in_d
//   in_ready   : stage can accept (registered)
//   in_d       : upstream data
//   out_valid  : out_d holds a valid entry
//   out_ready  : downstream accepts out_d
//   out_d      : main register contents
//   stall_cnt  : (macro only) stall cycle counter
//
// State table:
//   state     | meaning
//   OCC_EMPTY | nothing held, out_valid=0, in_ready=1
//   OCC_HALF  | main holds an entry, skid empty, in_ready=1
//   OCC_FULL  | main and skid both hold entries, in_ready=0
module pipe_skid_reg
    import pipe_pkg::*;
#(
    parameter int               WIDTH   = PIPE_DEF_WIDTH,
    parameter logic [WIDTH-1:0] RST_VAL = {WIDTH{1'b0}}
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_d,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_d
`ifdef PIPE_SKID_STALL_CNT_EN
    ,
    output logic [PIPE_STALL_CNT_W-1:0] stall_cnt
`endif
);

    pipe_occ_t        r_state;
    pipe_occ_t        w_state_nxt;
    logic             r_in_ready;
    logic             r_out_valid;
    logic             w_push;
    logic             w_pop;
    logic             w_main_load;
    logic             w_skid_load;
    logic [WIDTH-1:0] w_main_d;
    logic [WIDTH-1:0] w_skid_q;

    assign w_push = in_valid & r_in_ready;
    assign w_pop  = r_out_valid & out_ready;

    always_comb begin
        w_state_nxt = r_state;
        w_main_load = 1'b0;
        w_skid_load = 1'b0;
        if (flush) begin
            // Data registers keep their (now meaningless) contents.
            w_state_nxt = OCC_EMPTY;
        end else begin
            case (r_state)
                OCC_EMPTY: begin
                    if (w_push) begin
                        w_state_nxt = OCC_HALF;
                        w_main_load = 1'b1;
                    end
                end
                OCC_HALF: begin
                    if (w_push && w_pop) begin
                        w_main_load = 1'b1;
                    end else if (w_push) begin
                        w_state_nxt = OCC_FULL;
                        w_skid_load = 1'b1;
                    end else if (w_pop) begin
                        w_state_nxt = OCC_EMPTY;
                    end
                end
                OCC_FULL: begin
                    if (w_pop) begin
                        w_state_nxt = OCC_HALF;
                        w_main_load = 1'b1;
                    end
                end
                default: begin
                    w_state_nxt = OCC_EMPTY;
                end
            endcase
        end
    end

    // In FULL the main register refills from the skid; otherwise straight from upstream.
    assign w_main_d = (r_state == OCC_FULL) ? w_skid_q : in_d;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state     <= OCC_EMPTY;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_in_ready  <= (w_state_nxt != OCC_FULL);
            r_out_valid <= (w_state_nxt != OCC_EMPTY);
        end
    end

    pipe_data_reg #(
        .WIDTH   (WIDTH),
        .RST_VAL (RST_VAL)
    ) u_main (
        .clk    (clk),
        .rst    (rst),
        .i_load (w_main_load),
        .i_d    (w_main_d),
        .o_q    (out_d)
    );

    pipe_data_reg #(
        .WIDTH   (WIDTH),
        .RST_VAL (RST_VAL)
    ) u_skid (
        .clk    (clk),
        .rst    (rst),
        .i_load (w_skid_load),
        .i_d    (in_d),
        .o_q    (w_skid_q)
    );

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;

`ifdef PIPE_SKID_STALL_CNT_EN
    logic [PIPE_STALL_CNT_W-1:0] r_stall_cnt;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_stall_cnt <= '0;
        end else if (r_out_valid && !out_ready && (r_stall_cnt != {PIPE_STALL_CNT_W{1'b1}})) begin
            r_stall_cnt <= r_stall_cnt + 1'b1;
        end
    end

    assign stall_cnt = r_stall_cnt;
`endif

endmodule

// File: tb/tb_pipe_skid_reg.sv
module tb_pipe_skid_reg;

    localparam logic [31:0] TB_RST = 32'h1234_5678;

    logic        clk;
    logic        rst;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_d;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_d;
`ifdef PIPE_SKID_STALL_CNT_EN
    logic [31:0] stall_cnt;
`endif

    pipe_skid_reg #(
        .WIDTH   (32),
        .RST_VAL (TB_RST)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_d      (in_d),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_d     (out_d)
`ifdef PIPE_SKID_STALL_CNT_EN
        ,
        .stall_cnt (stall_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        r;
        logic        f;
        logic        iv;
        logic [31:0] d;
        logic        ordy;
        logic        e_ov;
        logic        e_ir;
        logic [31:0] e_d;
        logic        chk_d;
    } vec_t;

    vec_t        vecs[$];
    logic [31:0] sb[$];
    int          errors = 0;
    int          checks = 0;

    function automatic vec_t mk(logic r, logic f, logic iv, logic [31:0] d, logic ordy,
                                logic e_ov, logic e_ir, logic [31:0] e_d, logic chk_d);
        vec_t v;
        v.r = r; v.f = f; v.iv = iv; v.d = d; v.ordy = ordy;
        v.e_ov = e_ov; v.e_ir = e_ir; v.e_d = e_d; v.chk_d = chk_d;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Drives one cycle and keeps the scoreboard model in step.
    task automatic cycle(input logic r, input logic f, input logic iv,
                         input logic [31:0] d, input logic ordy);
        logic [31:0] exp;
        bit          m_push;
        bit          m_pop;
        rst = r; flush = f; in_valid = iv; in_d = d; out_ready = ordy;
        m_push = 0;
        m_pop  = 0;
        if (!r) begin
            sb.delete();
        end else if (f) begin
            sb.delete();
        end else begin
            m_pop  = (sb.size() > 0) && ordy;
            m_push = iv && (sb.size() < 2);
            if (m_pop) begin
                exp = sb.pop_front();
                chk("sb_pop", out_d, exp);
            end
            if (m_push) sb.push_back(d);
        end
        @(posedge clk);
        #1;
        chk("model_out_valid", {31'd0, out_valid}, {31'd0, sb.size() > 0});
        chk("model_in_ready", {31'd0, in_ready}, {31'd0, sb.size() < 2});
        if (!r) chk("reset_out_d", out_d, TB_RST);
        else if (sb.size() > 0) chk("sb_head", out_d, sb[0]);
    endtask

    initial begin
        rst = 1'b0; flush = 1'b0; in_valid = 1'b0; in_d = '0; out_ready = 1'b0;

        // reset with handshake noise
        vecs.push_back(mk(0,0,1,32'hDEAD_BEEF,1, 0,1,TB_RST,1));
        vecs.push_back(mk(0,0,1,32'hDEAD_BEEF,1, 0,1,TB_RST,1));
        // streaming
        vecs.push_back(mk(1,0,1,32'd1,1, 1,1,32'd1,1));
        vecs.push_back(mk(1,0,1,32'd2,1, 1,1,32'd2,1));
        vecs.push_back(mk(1,0,1,32'd3,1, 1,1,32'd3,1));
        vecs.push_back(mk(1,0,1,32'd4,1, 1,1,32'd4,1));
        vecs.push_back(mk(1,0,0,32'd0,1, 0,1,32'd0,0));
        // backpressure
        vecs.push_back(mk(1,0,1,32'd10,0, 1,1,32'd10,1));
        vecs.push_back(mk(1,0,1,32'd11,0, 1,0,32'd10,1));
        vecs.push_back(mk(1,0,1,32'd12,0, 1,0,32'd10,1));
        vecs.push_back(mk(1,0,1,32'd12,1, 1,1,32'd11,1));
        vecs.push_back(mk(1,0,1,32'd12,1, 1,1,32'd12,1));
        vecs.push_back(mk(1,0,0,32'd0,1, 0,1,32'd0,0));
        // flush in FULL
        vecs.push_back(mk(1,0,1,32'd20,0, 1,1,32'd20,1));
        vecs.push_back(mk(1,0,1,32'd21,0, 1,0,32'd20,1));
        vecs.push_back(mk(1,1,1,32'd22,0, 0,1,32'd0,0));
        vecs.push_back(mk(1,0,0,32'd0,1, 0,1,32'd0,0));
        // reset mid-stall
        vecs.push_back(mk(1,0,1,32'd30,0, 1,1,32'd30,1));
        vecs.push_back(mk(1,0,1,32'd31,0, 1,0,32'd30,1));
        vecs.push_back(mk(0,0,1,32'd32,1, 0,1,TB_RST,1));
        vecs.push_back(mk(1,0,1,32'd5,0, 1,1,32'd5,1));
        vecs.push_back(mk(1,0,0,32'd0,1, 0,1,32'd0,0));

        for (int i = 0; i < vecs.size(); i++) begin
            cycle(vecs[i].r, vecs[i].f, vecs[i].iv, vecs[i].d, vecs[i].ordy);
            chk($sformatf("vec%0d_out_valid", i), {31'd0, out_valid}, {31'd0, vecs[i].e_ov});
            chk($sformatf("vec%0d_in_ready", i), {31'd0, in_ready}, {31'd0, vecs[i].e_ir});
            if (vecs[i].chk_d) chk($sformatf("vec%0d_out_d", i), out_d, vecs[i].e_d);
        end

        // random traffic against the scoreboard
        for (int i = 0; i < 200; i++) begin
            cycle(1'b1, ($urandom_range(0, 19) == 0), 1'(($urandom_range(0, 3) != 0)),
                  $urandom, 1'($urandom_range(0, 1)));
        end
        // drain
        for (int i = 0; i < 4; i++) cycle(1'b1, 1'b0, 1'b0, 32'd0, 1'b1);
        chk("drain_empty", {31'd0, out_valid}, 32'd0);

`ifdef PIPE_SKID_STALL_CNT_EN
        cycle(1'b0, 1'b0, 1'b0, 32'd0, 1'b0);
        chk("stall_reset", stall_cnt, 32'd0);
        cycle(1'b1, 1'b0, 1'b1, 32'd40, 1'b0);
        repeat (7) cycle(1'b1, 1'b0, 1'b0, 32'd0, 1'b0);
        chk("stall_7", stall_cnt, 32'd7);
        cycle(1'b1, 1'b1, 1'b0, 32'd0, 1'b1);
        chk("stall_after_flush", stall_cnt, 32'd7);
        dut.r_stall_cnt = 32'hFFFF_FFFE;
        cycle(1'b1, 1'b0, 1'b1, 32'd41, 1'b0);
        repeat (3) cycle(1'b1, 1'b0, 1'b0, 32'd0, 1'b0);
        chk("stall_saturate", stall_cnt, 32'hFFFF_FFFF);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
